// File: rtl/mono_video_out_pkg.sv
// Shared timing defaults, framebuffer geometry and output bundle for the mono scanout path.
package mono_video_out_pkg;

    localparam int DEF_WIDTH        = 512;
    localparam int DEF_HEIGHT       = 342;
    localparam int DEF_H_TOTAL      = 704;
    localparam int DEF_H_SYNC_START = 526;
    localparam int DEF_H_SYNC_END   = 704;
    localparam int DEF_V_TOTAL      = 370;
    localparam int DEF_V_SYNC_START = 342;
    localparam int DEF_V_SYNC_END   = 346;

    localparam int WORDS_PER_LINE = DEF_WIDTH / 16;
    localparam int FB_AW          = $clog2(DEF_HEIGHT * WORDS_PER_LINE);
    localparam int CW             = 12;

    typedef struct packed {
        logic video;
        logic hsync_n;
        logic vsync_n;
        logic frame_strobe;
    } vid_out_t;

    localparam vid_out_t OUT_RESET = '{video: 1'b0, hsync_n: 1'b1, vsync_n: 1'b1, frame_strobe: 1'b0};

    // Linear word index y*wpl + xw, wide enough that no legal coordinate overflows.
    function automatic logic [2*CW-1:0] fb_lin(input logic [CW-1:0] y, input logic [CW-5:0] xw,
                                               input int wpl);
        return {{CW{1'b0}}, y} * (2*CW)'(wpl) + {{(CW+4){1'b0}}, xw};
    endfunction

endpackage

// File: rtl/mono_fb_ram.sv
// Simple dual-port 16-bit framebuffer RAM: one write port, one registered read port (read-old on collision).
module mono_fb_ram
    import mono_video_out_pkg::*;
#(
    parameter int DEPTH = DEF_HEIGHT * WORDS_PER_LINE,
    parameter int AW    = FB_AW
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [15:0]   wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [15:0]   rdata_o
);

    logic [15:0] mem_q [DEPTH];

    // NOTE: no reset on the array or read register, so the tools can map this onto block RAM.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_o <= mem_q[raddr_i];
    end

endmodule

// File: rtl/mono_video_out.sv
// Framebuffer-backed 1bpp video scanout: dot-clock timing generator plus a 3-stage pixel/sync pipeline.
module mono_video_out
    import mono_video_out_pkg::*;
#(
    parameter int WIDTH        = DEF_WIDTH,
    parameter int HEIGHT       = DEF_HEIGHT,
    parameter int H_TOTAL      = DEF_H_TOTAL,
    parameter int H_SYNC_START = DEF_H_SYNC_START,
    parameter int H_SYNC_END   = DEF_H_SYNC_END,
    parameter int V_TOTAL      = DEF_V_TOTAL,
    parameter int V_SYNC_START = DEF_V_SYNC_START,
    parameter int V_SYNC_END   = DEF_V_SYNC_END
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [15:0]   bits,
    input  logic [CW-1:0] xaddr,
    input  logic [CW-1:0] yaddr,
    input  logic          bits_ready,
    output logic          video,
    output logic          hsync,
    output logic          vsync,
    output logic          frame_strobe
);

    localparam int WPL   = WIDTH / 16;
    localparam int DEPTH = HEIGHT * WPL;
    localparam int AW    = $clog2(DEPTH);

    localparam logic [CW-1:0] WIDTH_C  = CW'(WIDTH);
    localparam logic [CW-1:0] HEIGHT_C = CW'(HEIGHT);
    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] HSS_C    = CW'(H_SYNC_START);
    localparam logic [CW-1:0] HSE_C    = CW'(H_SYNC_END);
    localparam logic [CW-1:0] VSS_C    = CW'(V_SYNC_START);
    localparam logic [CW-1:0] VSE_C    = CW'(V_SYNC_END);

    logic [CW-1:0] h_q, h_d, v_q, v_d;
    logic          active0, wr_en;
    logic [AW-1:0] raddr, waddr;
    logic [15:0]   rdata;
    logic          unused_xaddr_lsbs;

    logic [3:0] px1_q;
    logic       valid1_q, act1_q, hs_n1_q, vs_n1_q, fs1_q;
    vid_out_t   out_d, out_q;

    always_comb begin : counter_next
        // NOTE: defaults come first so every path assigns h_d/v_d and no latch is inferred.
        h_d = h_q + CW'(1);
        v_d = v_q;
        if (h_q == H_LAST) begin
            h_d = '0;
            v_d = (v_q == V_LAST) ? '0 : v_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin : counter_reg
        // NOTE: non-blocking assignments make every register sample pre-edge values.
        if (reset) begin
            h_q <= '0;
            v_q <= '0;
        end else begin
            h_q <= h_d;
            v_q <= v_d;
        end
    end

    assign active0 = (h_q < WIDTH_C) && (v_q < HEIGHT_C);
    assign raddr   = active0 ? AW'(fb_lin(v_q, h_q[CW-1:4], WPL)) : '0;

    // Out-of-range words (including the wrapped 0xFF0 line-start base) are dropped here.
    assign wr_en = bits_ready && (xaddr < WIDTH_C) && (yaddr < HEIGHT_C);
    assign waddr = AW'(fb_lin(yaddr, xaddr[CW-1:4], WPL));
    assign unused_xaddr_lsbs = ^xaddr[3:0];

    mono_fb_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fb_ram (
        .clk     (clk),
        .we_i    (wr_en),
        .waddr_i (waddr),
        .wdata_i (bits),
        .raddr_i (raddr),
        .rdata_o (rdata)
    );

    // Stage 1 carries the position-derived terms alongside the RAM read.
    always_ff @(posedge clk) begin : stage1_reg
        if (reset) begin
            valid1_q <= 1'b0;
            px1_q    <= '0;
            act1_q   <= 1'b0;
            hs_n1_q  <= 1'b1;
            vs_n1_q  <= 1'b1;
            fs1_q    <= 1'b0;
        end else begin
            valid1_q <= 1'b1;
            px1_q    <= h_q[3:0];
            act1_q   <= active0;
            hs_n1_q  <= !((h_q >= HSS_C) && (h_q < HSE_C));
            vs_n1_q  <= !((v_q >= VSS_C) && (v_q < VSE_C));
            fs1_q    <= (h_q == '0) && (v_q == HEIGHT_C);
        end
    end

    always_comb begin : stage2_next
        out_d = OUT_RESET;
        if (valid1_q) begin
            out_d.video        = act1_q & rdata[4'd15 - px1_q];
            out_d.hsync_n      = hs_n1_q;
            out_d.vsync_n      = vs_n1_q;
            out_d.frame_strobe = fs1_q;
        end
    end

    always_ff @(posedge clk) begin : stage2_reg
        if (reset) begin
            out_q <= OUT_RESET;
        end else begin
            out_q <= out_d;
        end
    end

    assign video        = out_q.video;
    assign hsync        = out_q.hsync_n;
    assign vsync        = out_q.vsync_n;
    assign frame_strobe = out_q.frame_strobe;

endmodule

// File: doc/mono_video_out.md
# mono_video_out

Display-side consumer of the dithered 1bpp stream. Accepts 16-pixel words with base X/Y addresses and a one-cycle ready strobe in the mono clock domain, stores them in an on-chip framebuffer, and scans the framebuffer out as serial 1bpp video with horizontal and vertical sync for an externally clocked monochrome display (512x342 class). `clk` is the dot clock: one pixel per cycle.

## Interface

- `WIDTH`, 512: active pixels per line; multiple of 16.
- `HEIGHT`, 342: active lines.
- `H_TOTAL`, 704: dot clocks per line.
- `H_SYNC_START`, 526 / `H_SYNC_END`, 704: hsync asserted for `H_SYNC_START <= h < H_SYNC_END`.
- `V_TOTAL`, 370: lines per frame.
- `V_SYNC_START`, 342 / `V_SYNC_END`, 346: vsync asserted for `V_SYNC_START <= v < V_SYNC_END`.
- `clk` in 1: dot clock. The block has one clock; reset is synchronous and active-high.
- `reset` in 1: synchronous, active-high.
- `bits` in 16: pixel word; bit 15 is pixel at `xaddr`, bit 0 is pixel `xaddr+15`; 1 = white.
- `xaddr` in 12: base X of word, low 4 bits zero.
- `yaddr` in 12: line of word.
- `bits_ready` in 1: one-cycle write strobe.
- `video` out 1: pixel, 1 = white, 0 in blanking.
- `hsync` out 1: active-low.
- `vsync` out 1: active-low.
- `frame_strobe` out 1: one-cycle pulse at start of vertical blanking.

## Operation

- Framebuffer: `HEIGHT * WIDTH/16` words x 16 bits, simple dual-port (one write, one read port), contents undefined at power-up and not cleared by reset.
- Write: on `bits_ready`, if `xaddr < WIDTH` and `yaddr < HEIGHT`, write `bits` at `yaddr*(WIDTH/16) + xaddr[11:4]`; otherwise drop silently (covers the wrapped `0xFF0` base emitted for the first word of a line). Low 4 bits of `xaddr` ignored. Writes never stall; no backpressure.
- Counters: `h` 0..`H_TOTAL-1`, wraps to 0 and increments `v`; `v` 0..`V_TOTAL-1`, wraps to 0. Both reset to 0.
- Active region: `h < WIDTH && v < HEIGHT`.
- Read: every cycle, read address `v*(WIDTH/16) + h[11:4]` (clamped don't-care outside active).
- Pixel select: `video = word[15 - h[3:0]]` using the one-cycle-delayed `h[3:0]`, forced 0 outside active.
- `frame_strobe` = 1 for the cycle where `h == 0 && v == HEIGHT` (pipelined like the other outputs).
- Read/write same-address collision: read returns old data; new data visible on the next frame.

## Timing

- Stage 0: counters, read address. Stage 1: BRAM data, delayed `h[3:0]`, active, sync terms. Stage 2: registered `video`, `hsync`, `vsync`, `frame_strobe`.
- Pixel/sync for counter position `(h,v)` appear on outputs exactly 2 cycles later; all four outputs share that latency, so the external view is self-consistent.
- Reset values: `video`=0, `hsync`=1, `vsync`=1, `frame_strobe`=0, pipeline valid bits cleared; outputs hold reset values for the first 2 cycles after `reset` falls.
- Reset mid-frame: counters restart at (0,0) on the cycle after reset; framebuffer kept.
- Write at cycle t is readable by a read issued at t+1 or later.
- Frame period `H_TOTAL*V_TOTAL` cycles = 260480 with defaults.

## Structure

- Shared package: default timing constants (`WIDTH`, `HEIGHT`, totals, sync bounds), `WORDS_PER_LINE = WIDTH/16`, framebuffer address width (`$clog2(HEIGHT*WORDS_PER_LINE)`, 14 with defaults).
- One sub-module: `mono_fb_ram`, simple dual-port 16-bit RAM with registered read, inferred to block RAM.
- Timing generator and pixel pipeline stay in the top module.

## Test plan

- Reset, then count: `hsync` low for 178 cycles each 704; `vsync` low for lines 342..345; `frame_strobe` exactly once per 260480 cycles, 2 cycles after counters hit (0,342).
- Write `bits=16'h8001` at (0,0), wait one frame: `video` = 1 at output cycles for x=0 and x=15 of line 0, 0 for x=1..14.
- Write `bits=16'hFFFF` at `xaddr=12'hFF0`, `yaddr=5` and at `yaddr=342`: framebuffer unchanged, line 5 and no wrap corruption.
- Fill all 10944 words with 16'hFFFF: `video`=1 for all 512x342 active positions, 0 for every blanking cycle.
- Write (496,341)=16'h0001 while scanout reads that address same cycle: current frame shows old value, next frame pixel (511,341)=1.
- Assert `reset` for one cycle mid-line 100: outputs return to reset values, next active pixel is (0,0) 2 cycles after counters restart, framebuffer content preserved.
